// File: rtl/imm_pkg.sv
// imm_pkg: immediate formats, skid occupancy states and RV32/64 base opcodes
package imm_pkg;
   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_R} imm_type_e;
   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate/format decode of one instruction
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      typ,
   output logic            illegal
);
   logic [31:0] raw;
   imm_type_e t;
   // every listed opcode ends in 2'b11, so non-32-bit encodings fall to default
   always_comb begin
      raw = '0;
      t = IMM_NONE;
      case (inst[6:0])
         OP_IMM, OP_LOAD, OP_JALR: begin raw = {{20{inst[31]}}, inst[31:20]}; t = IMM_I; end
         OP_STORE: begin raw = {{20{inst[31]}}, inst[31:25], inst[11:7]}; t = IMM_S; end
         OP_BRANCH: begin raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; t = IMM_B; end
         OP_JAL: begin raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; t = IMM_J; end
         OP_LUI, OP_AUIPC: begin raw = {inst[31:12], 12'b0}; t = IMM_U; end
         OP_OP: t = IMM_R;
         OP_SYSTEM: begin raw = inst[14] ? {27'b0, inst[19:15]} : '0; t = inst[14] ? IMM_Z : IMM_R; end
         default: ;
      endcase
   end
   assign typ = t;
   assign illegal = t == IMM_NONE;
   assign imm = XLEN'($signed(raw));
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate/target decode behind a two-entry skid buffer
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INST_WIDTH-1:0] in_inst,
   input  logic [XLEN-1:0]       in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_imm,
   output logic [XLEN-1:0]       out_target,
   output logic [XLEN-1:0]       out_pc,
   output logic [INST_WIDTH-1:0] out_inst,
   output logic [2:0]            out_type,
   output logic                  out_illegal
);
   typedef struct packed {
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       target;
      logic [XLEN-1:0]       pc;
      logic [INST_WIDTH-1:0] inst;
      logic [2:0]            typ;
      logic                  illegal;
   } entry_t;
   occ_e state, state_n;
   entry_t main_q, skid_q, fresh;
   logic [XLEN-1:0] imm;
   logic [2:0] typ;
   logic illegal, accept, pop, has_target;
   imm_extract #(.XLEN(XLEN)) u_extract (.inst(in_inst), .imm(imm), .typ(typ), .illegal(illegal));
   assign has_target = typ == IMM_B || typ == IMM_J || in_inst[6:0] == OP_AUIPC;
   assign fresh = '{imm: imm, target: has_target ? in_pc + imm : '0, pc: in_pc, inst: in_inst, typ: typ, illegal: illegal};
   assign accept = in_valid && in_ready;
   assign pop = out_valid && out_ready;
   always_ff @(posedge clk)
      if (rst) state <= EMPTY;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (flush) state_n = EMPTY;
      else
         case (state)
            EMPTY: state_n = accept ? ONE : EMPTY;
            ONE: state_n = accept && !pop ? TWO : pop && !accept ? EMPTY : ONE;
            TWO: state_n = pop ? ONE : TWO;
            default: state_n = EMPTY;
         endcase
   end
   always_comb begin
      in_ready = state != TWO;
      out_valid = state != EMPTY;
   end
   // main takes the skid entry on a pop from TWO, otherwise the freshly decoded one
   always_ff @(posedge clk)
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (state == TWO ? pop : accept && (state == EMPTY || pop)) main_q <= state == TWO ? skid_q : fresh;
         if (accept && state == ONE && !pop) skid_q <= fresh;
      end
   assign out_imm = main_q.imm;
   assign out_target = main_q.target;
   assign out_pc = main_q.pc;
   assign out_inst = main_q.inst;
   assign out_type = main_q.typ;
   assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed checks of decode, skid buffering, flush and reset
module tb_imm_decode_stage;
   import imm_pkg::*;
   logic clk = 0;
   logic rst, flush, in_valid, out_ready, in_ready, out_valid, out_illegal;
   logic [31:0] in_inst, in_pc, out_imm, out_target, out_pc, out_inst;
   logic [2:0] out_type;
   logic in_valid64, in_ready64, out_valid64, out_illegal64;
   logic [31:0] in_inst64, out_inst64;
   logic [63:0] in_pc64, out_imm64, out_target64, out_pc64;
   logic [2:0] out_type64;
   int pass = 0, total = 0;
   localparam int NV = 11;
   localparam logic [31:0] V_INST [NV] = '{32'hFFF00093, 32'hFE000EE3, 32'h00112423, 32'h0080006F, 32'h00001297,
      32'h3400D073, 32'h00000073, 32'h002081B3, 32'h00000000, 32'h0000007F, 32'hFFC08067};
   localparam logic [31:0] V_PC [NV] = '{32'h0, 32'h100, 32'h40, 32'h200, 32'h10, 32'h0, 32'h0, 32'h0, 32'h44, 32'h0, 32'h300};
   localparam logic [31:0] V_IMM [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h8, 32'h8, 32'h1000, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC};
   localparam logic [2:0] V_TYPE [NV] = '{IMM_I, IMM_B, IMM_S, IMM_J, IMM_U, IMM_Z, IMM_R, IMM_R, IMM_NONE, IMM_NONE, IMM_I};
   localparam logic V_ILL [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
   localparam logic [31:0] V_TGT [NV] = '{32'h0, 32'hFC, 32'h0, 32'h208, 32'h1010, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
   imm_decode_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_target(out_target), .out_pc(out_pc), .out_inst(out_inst), .out_type(out_type), .out_illegal(out_illegal));
   imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid64), .in_ready(in_ready64),
      .in_inst(in_inst64), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
      .out_target(out_target64), .out_pc(out_pc64), .out_inst(out_inst64), .out_type(out_type64), .out_illegal(out_illegal64));
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      rst = 1;
      tick();
      rst = 0;
   endtask
   task automatic push(input logic [31:0] inst, input logic [31:0] pc);
      in_valid = 1;
      in_inst = inst;
      in_pc = pc;
      tick();
      in_valid = 0;
   endtask
   task automatic test_reset;
      rst = 1;
      tick();
      tick();
      rst = 0;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else pass++;
      total++; if (out_imm !== 32'h0 || out_target !== 32'h0) $display("FAIL reset_imm_tgt: got %h/%h want 0/0", out_imm, out_target); else pass++;
      total++; if (out_pc !== 32'h0 || out_inst !== 32'h0) $display("FAIL reset_pc_inst: got %h/%h want 0/0", out_pc, out_inst); else pass++;
      total++; if (out_type !== IMM_NONE || out_illegal !== 1'b0) $display("FAIL reset_type: got %0d/%b want 0/0", out_type, out_illegal); else pass++;
   endtask
   task automatic test_decode;
      do_reset();
      out_ready = 1;
      for (int i = 0; i < NV; i++) begin
         push(V_INST[i], V_PC[i]);
         total++; if (out_valid !== 1'b1 || out_inst !== V_INST[i] || out_pc !== V_PC[i])
            $display("FAIL dec%0d_entry: got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h", i, out_valid, out_inst, out_pc, V_INST[i], V_PC[i]); else pass++;
         total++; if (out_imm !== V_IMM[i]) $display("FAIL dec%0d_imm: got %h want %h", i, out_imm, V_IMM[i]); else pass++;
         total++; if (out_type !== V_TYPE[i]) $display("FAIL dec%0d_type: got %0d want %0d", i, out_type, V_TYPE[i]); else pass++;
         total++; if (out_illegal !== V_ILL[i]) $display("FAIL dec%0d_illegal: got %b want %b", i, out_illegal, V_ILL[i]); else pass++;
         total++; if (out_target !== V_TGT[i]) $display("FAIL dec%0d_target: got %h want %h", i, out_target, V_TGT[i]); else pass++;
      end
   endtask
   task automatic test_xlen64;
      do_reset();
      out_ready = 1;
      in_valid64 = 1;
      in_inst64 = 32'h800000B7;
      in_pc64 = 64'h1000;
      tick();
      total++; if (out_valid64 !== 1'b1 || out_imm64 !== 64'hFFFFFFFF80000000) $display("FAIL x64_lui_imm: got v=%b %h want v=1 ffffffff80000000", out_valid64, out_imm64); else pass++;
      total++; if (out_type64 !== IMM_U || out_illegal64 !== 1'b0) $display("FAIL x64_lui_type: got %0d/%b want %0d/0", out_type64, out_illegal64, IMM_U); else pass++;
      total++; if (out_target64 !== 64'h0) $display("FAIL x64_lui_target: got %h want 0", out_target64); else pass++;
      in_inst64 = 32'h00000000;
      tick();
      in_valid64 = 0;
      total++; if (out_illegal64 !== 1'b1 || out_imm64 !== 64'h0) $display("FAIL x64_zero_illegal: got %b/%h want 1/0", out_illegal64, out_imm64); else pass++;
      total++; if (out_type64 !== IMM_NONE || out_valid64 !== 1'b1) $display("FAIL x64_zero_type: got %0d/v=%b want 0/v=1", out_type64, out_valid64); else pass++;
   endtask
   task automatic test_stream;
      logic [31:0] s [3];
      s[0] = 32'h00100093;
      s[1] = 32'h00200093;
      s[2] = 32'h00300093;
      do_reset();
      out_ready = 1;
      in_valid = 1;
      for (int i = 0; i < 3; i++) begin
         in_inst = s[i];
         in_pc = 32'(4 * i);
         tick();
         total++; if (out_valid !== 1'b1 || out_inst !== s[i] || out_imm !== 32'(i + 1))
            $display("FAIL stream%0d: got v=%b inst=%h imm=%h want v=1 inst=%h imm=%h", i, out_valid, out_inst, out_imm, s[i], 32'(i + 1)); else pass++;
         total++; if (in_ready !== 1'b1) $display("FAIL stream%0d_ready: got %b want 1", i, in_ready); else pass++;
      end
      in_valid = 0;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", out_valid); else pass++;
   endtask
   task automatic test_back_to_back;
      do_reset();
      out_ready = 0;
      push(32'h00500093, 32'h20);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b1) $display("FAIL b2b_one: got rdy=%b v=%b want 1/1", in_ready, out_valid); else pass++;
      push(32'h00600093, 32'h24);
      total++; if (in_ready !== 1'b0) $display("FAIL b2b_full: got %b want 0", in_ready); else pass++;
      tick();
      tick();
      total++; if (out_inst !== 32'h00500093 || out_imm !== 32'h5 || out_pc !== 32'h20)
         $display("FAIL b2b_stable: got %h/%h/%h want 00500093/5/20", out_inst, out_imm, out_pc); else pass++;
      out_ready = 1;
      total++; if (out_valid !== 1'b1 || out_inst !== 32'h00500093) $display("FAIL b2b_first: got v=%b %h want v=1 00500093", out_valid, out_inst); else pass++;
      tick();
      total++; if (out_valid !== 1'b1 || out_inst !== 32'h00600093 || out_imm !== 32'h6 || out_pc !== 32'h24)
         $display("FAIL b2b_second: got v=%b %h/%h/%h want v=1 00600093/6/24", out_valid, out_inst, out_imm, out_pc); else pass++;
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_back: got %b want 1", in_ready); else pass++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", out_valid); else pass++;
   endtask
   task automatic test_flush;
      do_reset();
      out_ready = 0;
      push(32'h00500093, 32'h0);
      push(32'h00600093, 32'h4);
      in_valid = 1;
      in_inst = 32'h00700093;
      flush = 1;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL flush_pre_ready: got %b want 0", in_ready); else pass++;
      tick();
      flush = 0;
      in_valid = 0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_two: got v=%b rdy=%b want 0/1", out_valid, in_ready); else pass++;
      push(32'h00800093, 32'h8);
      in_valid = 1;
      in_inst = 32'h00900093;
      flush = 1;
      tick();
      flush = 0;
      in_valid = 0;
      total++; if (out_valid !== 1'b0) $display("FAIL flush_beats_accept: got %b want 0", out_valid); else pass++;
      out_ready = 1;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL flush_nothing_left: got %b want 0", out_valid); else pass++;
   endtask
   task automatic test_rst_mid;
      out_ready = 0;
      push(32'hFE000EE3, 32'h100);
      push(32'h00001297, 32'h10);
      rst = 1;
      in_valid = 1;
      in_inst = 32'h00100093;
      flush = 1;
      tick();
      rst = 0;
      flush = 0;
      in_valid = 0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_two: got v=%b rdy=%b want 0/1", out_valid, in_ready); else pass++;
      total++; if (out_imm !== 32'h0 || out_target !== 32'h0 || out_pc !== 32'h0 || out_inst !== 32'h0)
         $display("FAIL rst_payload: got %h/%h/%h/%h want all 0", out_imm, out_target, out_pc, out_inst); else pass++;
      total++; if (out_type !== IMM_NONE || out_illegal !== 1'b0) $display("FAIL rst_type: got %0d/%b want 0/0", out_type, out_illegal); else pass++;
      out_ready = 1;
      tick();
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL rst_no_ghost: got %b want 0", out_valid); else pass++;
   endtask
   initial begin
      rst = 0;
      flush = 0;
      in_valid = 0;
      in_inst = '0;
      in_pc = '0;
      out_ready = 0;
      in_valid64 = 0;
      in_inst64 = '0;
      in_pc64 = '0;
      #1;
      test_reset();
      test_decode();
      test_xlen64();
      test_stream();
      test_back_to_back();
      test_flush();
      test_rst_mid();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
